// File: rtl/cycle_trace_dumper.sv
// cycle_trace_dumper: steps a stalled CPU one cycle at a time and streams PC + register-file snapshots.
// Revision 1.0
`default_nettype none

module cycle_trace_dumper #(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int IDX_W      = 5,
  parameter int MAX_CYCLES = 10,
  parameter int MODE       = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] pc_i,
  output logic [IDX_W-1:0]  reg_addr_o,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic              cpu_stall_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_tag_o,
  output logic [IDX_W-1:0]  out_idx_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [15:0]       cycle_cnt_o,
  output logic              done_o
);

  localparam logic [15:0]      MAX_CNT  = 16'(MAX_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_PC_BEAT  = 3'd2,
    S_REG_BEAT = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t           state;
  logic             xfer;
  logic [IDX_W-1:0] next_idx;
  logic [15:0]      cnt_inc;

  assign xfer     = out_valid_o & out_ready_i;
  assign next_idx = out_idx_o + IDX_W'(1);
  // Saturating increment so the run counter can never wrap.
  assign cnt_inc  = (cycle_cnt_o == MAX_CNT) ? cycle_cnt_o : cycle_cnt_o + 16'd1;

  // Read-ahead address: the register the next REG_BEAT transfer will load.
  assign reg_addr_o = (state == S_REG_BEAT && out_idx_o != LAST_IDX) ? next_idx : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      cpu_stall_o <= 1'b1;
      out_valid_o <= 1'b0;
      out_tag_o   <= 1'b0;
      out_idx_o   <= '0;
      out_data_o  <= '0;
      cycle_cnt_o <= '0;
      done_o      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state       <= S_RUN;
            cpu_stall_o <= 1'b0;
          end
        end
        S_RUN: begin
          cycle_cnt_o <= cnt_inc;
          if (MODE == 0 || cnt_inc == MAX_CNT) begin
            state       <= S_PC_BEAT;
            cpu_stall_o <= 1'b1;
            out_valid_o <= 1'b1;
            out_tag_o   <= 1'b0;
            out_idx_o   <= '0;
            out_data_o  <= pc_i;
          end
        end
        S_PC_BEAT: begin
          if (xfer) begin
            state      <= S_REG_BEAT;
            out_tag_o  <= 1'b1;
            out_idx_o  <= '0;
            out_data_o <= reg_data_i;
          end
        end
        S_REG_BEAT: begin
          if (xfer) begin
            if (out_idx_o != LAST_IDX) begin
              out_idx_o  <= next_idx;
              out_data_o <= reg_data_i;
            end else begin
              out_valid_o <= 1'b0;
              if (cycle_cnt_o == MAX_CNT) begin
                state  <= S_DONE;
                done_o <= 1'b1;
              end else begin
                state       <= S_RUN;
                cpu_stall_o <= 1'b0;
              end
            end
          end
        end
        S_DONE: begin
          done_o <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cycle_trace_dumper.sv
// tb_cycle_trace_dumper: two instances (MODE0/MAX2 and MODE1/MAX3) against a snapshot-list reference model.
// Revision 1.0
`default_nettype none

module tb_cycle_trace_dumper;
  localparam int NR = 4;

  typedef struct packed {
    logic        tag;
    logic [1:0]  idx;
    logic [31:0] data;
    int          cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] start = '0;
  logic [1:0] ready = '0;
  wire  [1:0] valid, tag, stall, done;
  wire  [1:0][1:0]  idx, raddr;
  wire  [1:0][31:0] data, pc, rdata;
  wire  [1:0][15:0] cnt;

  // Regfile contents after n executed CPU cycles: regtab[dut][n][i]
  logic [31:0] regtab [2][4][NR];
  logic [31:0] pc_base [2];
  logic [31:0] pc_step [2];
  int run_cnt [2];
  int stall_low [2];
  int streak [2];
  int max_streak [2];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  beat_t got0[$], got1[$], expq[$];

  always #5 clk = ~clk;

  assign pc[0]    = pc_base[0] + pc_step[0] * 32'(run_cnt[0]);
  assign pc[1]    = pc_base[1] + pc_step[1] * 32'(run_cnt[1]);
  assign rdata[0] = regtab[0][run_cnt[0]][raddr[0]];
  assign rdata[1] = regtab[1][run_cnt[1]][raddr[1]];

  cycle_trace_dumper #(.DATA_W(32), .NUM_REGS(NR), .IDX_W(2), .MAX_CYCLES(2), .MODE(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .pc_i(pc[0]), .reg_addr_o(raddr[0]),
    .reg_data_i(rdata[0]), .cpu_stall_o(stall[0]), .out_valid_o(valid[0]), .out_ready_i(ready[0]),
    .out_tag_o(tag[0]), .out_idx_o(idx[0]), .out_data_o(data[0]), .cycle_cnt_o(cnt[0]), .done_o(done[0]));

  cycle_trace_dumper #(.DATA_W(32), .NUM_REGS(NR), .IDX_W(2), .MAX_CYCLES(3), .MODE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .pc_i(pc[1]), .reg_addr_o(raddr[1]),
    .reg_data_i(rdata[1]), .cpu_stall_o(stall[1]), .out_valid_o(valid[1]), .out_ready_i(ready[1]),
    .out_tag_o(tag[1]), .out_idx_o(idx[1]), .out_data_o(data[1]), .cycle_cnt_o(cnt[1]), .done_o(done[1]));

  // One clock: record transferred beats and let the CPU model advance when it was not stalled.
  task automatic step();
    logic [1:0] v, r, s;
    beat_t b [2];
    v = valid; r = ready; s = stall;
    for (int d = 0; d < 2; d++) begin
      b[d].tag = tag[d]; b[d].idx = idx[d]; b[d].data = data[d]; b[d].cyc = cyc;
    end
    @(posedge clk); #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        run_cnt[d] = 0; streak[d] = 0;
      end else begin
        if (v[d] && r[d]) begin
          if (d == 0) got0.push_back(b[d]); else got1.push_back(b[d]);
        end
        if (!s[d]) begin
          if (run_cnt[d] < 3) run_cnt[d]++;
          stall_low[d]++; streak[d]++;
          if (streak[d] > max_streak[d]) max_streak[d] = streak[d];
        end else begin
          streak[d] = 0;
        end
      end
    end
  endtask

  task automatic reset_duts();
    rst = 1'b1; start = '0; ready = '0;
    step();
    rst = 1'b0;
    got0.delete(); got1.delete();
    for (int d = 0; d < 2; d++) begin
      run_cnt[d] = 0; stall_low[d] = 0; streak[d] = 0; max_streak[d] = 0;
    end
  endtask

  task automatic fill_tables(input bit rnd);
    for (int d = 0; d < 2; d++) begin
      pc_base[d] = rnd ? ($urandom & 32'hFFFF_FFFC) : 32'h40;
      pc_step[d] = rnd ? 32'd4 : 32'd0;
      for (int n = 0; n < 4; n++)
        for (int i = 0; i < NR; i++)
          regtab[d][n][i] = rnd ? $urandom : 32'(i * 3);
    end
  endtask

  // Reference: MODE0 dumps after each of MAX cycles, MODE1 only after the last.
  // PC is the value seen during the run cycle; regs are the state after it.
  task automatic build_exp(input int d);
    int maxc;
    beat_t e;
    maxc = (d == 0) ? 2 : 3;
    expq.delete();
    for (int n = 1; n <= maxc; n++) begin
      if (d == 0 || n == maxc) begin
        e.tag = 1'b0; e.idx = 2'd0; e.data = pc_base[d] + pc_step[d] * 32'(n - 1); e.cyc = 0;
        expq.push_back(e);
        for (int i = 0; i < NR; i++) begin
          e.tag = 1'b1; e.idx = 2'(i); e.data = regtab[d][n][i];
          expq.push_back(e);
        end
      end
    end
  endtask

  task automatic run_dut(input int d, input int ready_pct, input int budget, output bit to);
    int k;
    k = 0; to = 1'b0;
    start[d] = 1'b1;
    while (done[d] !== 1'b1) begin
      if (k >= budget) begin to = 1'b1; break; end
      ready[d] = ($urandom_range(0, 99) < ready_pct);
      step(); k++;
    end
    ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 2'b11; ready = 2'b11;
    step(); step();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (stall[d] !== 1'b1 || valid[d] !== 1'b0 || tag[d] !== 1'b0 || idx[d] !== 2'd0 ||
          data[d] !== 32'd0 || cnt[d] !== 16'd0 || done[d] !== 1'b0 || raddr[d] !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: stall=%b valid=%b tag=%b idx=%0d data=%h cnt=%0d done=%b raddr=%0d, want 1 0 0 0 0 0 0 0",
                 d, stall[d], valid[d], tag[d], idx[d], data[d], cnt[d], done[d], raddr[d]);
      end
    end
    rst = 1'b0; start = '0; ready = '0;
  endtask

  task automatic test_idle_no_start();
    reset_duts();
    for (int k = 0; k < 20; k++) begin
      ready = 2'($urandom);
      step();
      n_checks++;
      if (stall !== 2'b11 || valid !== 2'b00 || cnt[0] !== 16'd0 || cnt[1] !== 16'd0) begin
        n_fail++;
        $display("FAIL idle_hold cyc%0d: stall=%b valid=%b cnt0=%0d cnt1=%0d, want 11 00 0 0",
                 k, stall, valid, cnt[0], cnt[1]);
      end
    end
    n_checks++;
    if (got0.size() != 0 || got1.size() != 0) begin
      n_fail++;
      $display("FAIL idle_beats: got %0d/%0d beats, want 0/0", got0.size(), got1.size());
    end
  endtask

  task automatic test_mode0_payload();
    bit to;
    reset_duts(); fill_tables(1'b0);
    build_exp(0);
    run_dut(0, 100, 100, to);
    n_checks++;
    if (to || got0.size() != expq.size()) begin
      n_fail++;
      $display("FAIL m0_count: timeout=%b beats=%0d, want 0 %0d", to, got0.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < got0.size(); i++) begin
      n_checks++;
      if (got0[i].tag !== expq[i].tag || got0[i].idx !== expq[i].idx || got0[i].data !== expq[i].data) begin
        n_fail++;
        $display("FAIL m0_beat%0d: tag=%b idx=%0d data=%h, want %b %0d %h", i,
                 got0[i].tag, got0[i].idx, got0[i].data, expq[i].tag, expq[i].idx, expq[i].data);
      end
      if (i % (NR + 1) != 0) begin
        n_checks++;
        if (got0[i].cyc !== got0[i-1].cyc + 1) begin
          n_fail++;
          $display("FAIL m0_back_to_back beat%0d: cycle %0d, want %0d", i, got0[i].cyc, got0[i-1].cyc + 1);
        end
      end
    end
    n_checks++;
    if (stall_low[0] != 2 || done[0] !== 1'b1 || cnt[0] !== 16'd2) begin
      n_fail++;
      $display("FAIL m0_end: stall_low=%0d done=%b cnt=%0d, want 2 1 2", stall_low[0], done[0], cnt[0]);
    end
  endtask

  task automatic test_done_sticky();
    for (int k = 0; k < 10; k++) begin
      start[0] = ~start[0];
      ready[0] = 1'b1;
      step();
      n_checks++;
      if (done[0] !== 1'b1 || stall[0] !== 1'b1 || valid[0] !== 1'b0 || cnt[0] !== 16'd2) begin
        n_fail++;
        $display("FAIL done_sticky cyc%0d: done=%b stall=%b valid=%b cnt=%0d, want 1 1 0 2",
                 k, done[0], stall[0], valid[0], cnt[0]);
      end
    end
    start[0] = 1'b0; ready[0] = 1'b0;
  endtask

  task automatic test_mode1();
    bit to;
    reset_duts(); fill_tables(1'b1);
    build_exp(1);
    run_dut(1, 100, 100, to);
    n_checks++;
    if (to || got1.size() != expq.size()) begin
      n_fail++;
      $display("FAIL m1_count: timeout=%b beats=%0d, want 0 %0d", to, got1.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < got1.size(); i++) begin
      n_checks++;
      if (got1[i].tag !== expq[i].tag || got1[i].idx !== expq[i].idx || got1[i].data !== expq[i].data) begin
        n_fail++;
        $display("FAIL m1_beat%0d: tag=%b idx=%0d data=%h, want %b %0d %h", i,
                 got1[i].tag, got1[i].idx, got1[i].data, expq[i].tag, expq[i].idx, expq[i].data);
      end
    end
    n_checks++;
    if (stall_low[1] != 3 || max_streak[1] != 3 || done[1] !== 1'b1 || cnt[1] !== 16'd3) begin
      n_fail++;
      $display("FAIL m1_end: stall_low=%0d streak=%0d done=%b cnt=%0d, want 3 3 1 3",
               stall_low[1], max_streak[1], done[1], cnt[1]);
    end
  endtask

  task automatic test_backpressure();
    bit held;
    int k;
    held = 1'b0; k = 0;
    reset_duts(); fill_tables(1'b1);
    build_exp(0);
    start[0] = 1'b1; ready[0] = 1'b1;
    while (done[0] !== 1'b1 && k < 200) begin
      if (!held && valid[0] === 1'b1 && tag[0] === 1'b1 && idx[0] === 2'd2) begin
        held = 1'b1; ready[0] = 1'b0;
        for (int j = 0; j < 3; j++) begin
          step(); k++;
          n_checks++;
          if (valid[0] !== 1'b1 || tag[0] !== 1'b1 || idx[0] !== 2'd2 ||
              data[0] !== regtab[0][1][2] || stall[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold%0d: valid=%b tag=%b idx=%0d data=%h stall=%b, want 1 1 2 %h 1",
                     j, valid[0], tag[0], idx[0], data[0], stall[0], regtab[0][1][2]);
          end
        end
        ready[0] = 1'b1;
      end
      step(); k++;
    end
    ready[0] = 1'b0;
    n_checks++;
    if (!held || done[0] !== 1'b1 || got0.size() != expq.size()) begin
      n_fail++;
      $display("FAIL bp_end: held=%b done=%b beats=%0d, want 1 1 %0d", held, done[0], got0.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < got0.size(); i++) begin
      n_checks++;
      if (got0[i].tag !== expq[i].tag || got0[i].idx !== expq[i].idx || got0[i].data !== expq[i].data) begin
        n_fail++;
        $display("FAIL bp_beat%0d: tag=%b idx=%0d data=%h, want %b %0d %h", i,
                 got0[i].tag, got0[i].idx, got0[i].data, expq[i].tag, expq[i].idx, expq[i].data);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int k;
    k = 0;
    reset_duts(); fill_tables(1'b1);
    start[0] = 1'b1; ready[0] = 1'b1;
    while (!(valid[0] === 1'b1 && tag[0] === 1'b1 && idx[0] === 2'd1) && k < 50) begin
      step(); k++;
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (valid[0] !== 1'b0 || cnt[0] !== 16'd0 || stall[0] !== 1'b1 || tag[0] !== 1'b0 ||
        idx[0] !== 2'd0 || data[0] !== 32'd0 || raddr[0] !== 2'd0 || got0.size() != 2) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b cnt=%0d stall=%b tag=%b idx=%0d data=%h raddr=%0d beats=%0d, want 0 0 1 0 0 0 0 2",
               valid[0], cnt[0], stall[0], tag[0], idx[0], data[0], raddr[0], got0.size());
    end
    rst = 1'b0;
    got0.delete(); stall_low[0] = 0;
    build_exp(0);
    run_dut(0, 100, 100, to);
    n_checks++;
    if (to || got0.size() != expq.size()) begin
      n_fail++;
      $display("FAIL rerun_count: timeout=%b beats=%0d, want 0 %0d", to, got0.size(), expq.size());
    end
    for (int i = 0; i < expq.size() && i < got0.size(); i++) begin
      n_checks++;
      if (got0[i].tag !== expq[i].tag || got0[i].idx !== expq[i].idx || got0[i].data !== expq[i].data) begin
        n_fail++;
        $display("FAIL rerun_beat%0d: tag=%b idx=%0d data=%h, want %b %0d %h", i,
                 got0[i].tag, got0[i].idx, got0[i].data, expq[i].tag, expq[i].idx, expq[i].data);
      end
    end
  endtask

  task automatic test_random_ready();
    bit to;
    beat_t g[$];
    for (int it = 0; it < 3; it++) begin
      for (int d = 0; d < 2; d++) begin
        reset_duts(); fill_tables(1'b1);
        build_exp(d);
        run_dut(d, 60, 400, to);
        if (d == 0) g = got0; else g = got1;
        n_checks++;
        if (to || g.size() != expq.size() || stall_low[d] != ((d == 0) ? 2 : 3)) begin
          n_fail++;
          $display("FAIL rnd%0d_dut%0d_count: timeout=%b beats=%0d stall_low=%0d, want 0 %0d %0d",
                   it, d, to, g.size(), stall_low[d], expq.size(), (d == 0) ? 2 : 3);
        end
        for (int i = 0; i < expq.size() && i < g.size(); i++) begin
          n_checks++;
          if (g[i].tag !== expq[i].tag || g[i].idx !== expq[i].idx || g[i].data !== expq[i].data) begin
            n_fail++;
            $display("FAIL rnd%0d_dut%0d_beat%0d: tag=%b idx=%0d data=%h, want %b %0d %h", it, d, i,
                     g[i].tag, g[i].idx, g[i].data, expq[i].tag, expq[i].idx, expq[i].data);
          end
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      run_cnt[d] = 0; stall_low[d] = 0; streak[d] = 0; max_streak[d] = 0;
    end
    fill_tables(1'b0);
    test_reset();
    test_idle_no_start();
    test_mode0_payload();
    test_done_sticky();
    test_mode1();
    test_backpressure();
    test_reset_mid();
    test_random_ready();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cycle_trace_dumper.md
CYCLE_TRACE_DUMPER -- requirements
Module: cycle_trace_dumper

Interface
REQ-001 Parameter DATA_W, default 32, width of PC and register data.
REQ-002 Parameter NUM_REGS, default 32, number of register-file entries dumped per snapshot (2..256).
REQ-003 Parameter IDX_W, default 5, width of register index; SHALL satisfy 2**IDX_W >= NUM_REGS.
REQ-004 Parameter MAX_CYCLES, default 10, number of CPU run cycles before stop (1..65535).
REQ-005 Parameter MODE, default 0; 0 = snapshot after every run cycle, 1 = single snapshot after the last run cycle.
REQ-006 clk_i  in  1  single clock, all logic on rising edge.
REQ-007 rst_i  in  1  reset, synchronous, active-high.
REQ-008 start_i  in  1  level; begins the run when sampled high in IDLE.
REQ-009 pc_i  in  DATA_W  current CPU PC.
REQ-010 reg_addr_o  out  IDX_W  register-file read index (combinational read port).
REQ-011 reg_data_i  in  DATA_W  register-file read data for reg_addr_o, same cycle.
REQ-012 cpu_stall_o  out  1  high = CPU SHALL hold all state this cycle.
REQ-013 out_valid_o  out  1  beat valid.
REQ-014 out_ready_i  in  1  sink accepts beat.
REQ-015 out_tag_o  out  1  0 = PC beat, 1 = register beat.
REQ-016 out_idx_o  out  IDX_W  register index of beat (0 on PC beat).
REQ-017 out_data_o  out  DATA_W  beat payload.
REQ-018 cycle_cnt_o  out  16  completed run cycles.
REQ-019 done_o  out  1  high in DONE.

Function
REQ-020 States: IDLE, RUN, PC_BEAT, REG_BEAT, DONE; all outputs registered except reg_addr_o.
REQ-021 IDLE: cpu_stall_o=1, out_valid_o=0; start_i=1 -> RUN next cycle, else stay.
REQ-022 RUN: cpu_stall_o=0 for exactly one cycle; cycle_cnt_o increments by 1 at its end.
REQ-023 RUN exit, MODE 0: -> PC_BEAT. MODE 1: -> PC_BEAT only if incremented count == MAX_CYCLES, else stay RUN.
REQ-024 On RUN->PC_BEAT edge: out_data_o <= pc_i, out_tag_o <= 0, out_idx_o <= 0, out_valid_o <= 1.
REQ-025 cpu_stall_o=1 in PC_BEAT, REG_BEAT, DONE, IDLE.
REQ-026 Handshake: beat transfers on rising edge with out_valid_o & out_ready_i; payload/tag/idx SHALL hold stable while out_valid_o & !out_ready_i; out_valid_o never drops without transfer except on reset.
REQ-027 reg_addr_o = index of next register beat to load; 0 outside REG_BEAT.
REQ-028 PC transfer -> REG_BEAT, loads reg_data_i (index 0), tag 1, idx 0.
REQ-029 REG_BEAT transfer with idx < NUM_REGS-1: loads next index, valid stays high (back-to-back beats, no bubble).
REQ-030 Transfer of idx NUM_REGS-1: out_valid_o <= 0; -> DONE if cycle_cnt_o == MAX_CYCLES, else -> RUN.
REQ-031 Each snapshot = exactly NUM_REGS+1 beats, PC first, indices ascending.
REQ-032 DONE: terminal, done_o=1, start_i ignored; only rst_i leaves.
REQ-033 start_i ignored outside IDLE; deassertion mid-run has no effect.
REQ-034 cycle_cnt_o saturates at MAX_CYCLES; never wraps.

Reset
REQ-035 rst_i high at a clock edge -> next cycle: IDLE, cpu_stall_o=1, out_valid_o=0, out_tag_o=0, out_idx_o=0, out_data_o=0, cycle_cnt_o=0, done_o=0, reg_addr_o=0.
REQ-036 Reset dominates start_i and any in-flight handshake; a beat pending at reset is discarded, not transferred.

Verification
REQ-037 MODE0, NUM_REGS=4, MAX_CYCLES=2, ready=1, start held -> 2 snapshots of 5 beats (tags 0,1,1,1,1; idx 0,0,1,2,3), cpu_stall_o low exactly 2 cycles, done_o=1, cycle_cnt_o=2.
REQ-038 MODE1, NUM_REGS=4, MAX_CYCLES=3 -> stall low 3 consecutive cycles, then one 5-beat snapshot, DONE.
REQ-039 Back-pressure: ready low 3 cycles on reg beat idx 2 -> valid held, data/idx unchanged, CPU stalled, then transfer and continue.
REQ-040 Reset asserted during REG_BEAT idx 1 -> next cycle valid=0, cycle_cnt_o=0, IDLE; rerun with start produces full sequence from PC beat.
REQ-041 start_i low 20 cycles after reset -> stall high, no beats, cycle_cnt_o=0; start_i toggled in DONE -> no change.
REQ-042 Register payload check: regfile model x[i]=i*3, pc_i=0x40 -> PC beat 0x40, reg beats 0,3,6,9.
